// File: rtl/program_load_pkg.sv
// Shared types and constants for the SPART program loader.
package program_load_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_PC,
        ST_HDR_CNT,
        ST_CHECK,
        ST_DATA,
        ST_SWITCH,
        ST_ERR
    } state_e;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int         BYTE_IDX_W    = 2;
    localparam logic [BYTE_IDX_W-1:0] LAST_BYTE_IDX = 2'd3;
    localparam logic [BYTE_IDX_W-1:0] BYTE_IDX_ONE  = 2'd1;

endpackage

// File: rtl/program_load_ctrl_byte_packer.sv
// Assembles four MSB-first bytes into a 32-bit word; word_done_o strobes
// combinationally with the fourth byte so the caller can register it that cycle.
module byte_packer
    import program_load_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_done_o
);

    logic [23:0]           shift_q, shift_d;
    logic [BYTE_IDX_W-1:0] idx_q, idx_d;

    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        if (clear_i) begin
            shift_d = '0;
            idx_d   = '0;
        end else if (byte_valid_i) begin
            shift_d = {shift_q[15:0], byte_i};
            idx_d   = idx_q + BYTE_IDX_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

    // The last three bytes always sit in shift_q, so the word is complete the
    // same cycle its final byte arrives.
    assign word_o      = {shift_q, byte_i};
    assign word_done_o = byte_valid_i && !clear_i && (idx_q == LAST_BYTE_IDX);

endmodule

// File: rtl/program_load_ctrl.sv
// Loads a program frame from the SPART byte stream into IMEM and restarts the
// core at the frame's entry PC.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for SYNC; other bytes dropped
// ST_HDR_PC  | collecting 4-byte entry PC
// ST_HDR_CNT | collecting 4-byte word count N
// ST_CHECK   | one cycle: validate PC/N, latch SPART_pc
// ST_DATA    | writing N words to IMEM
// ST_SWITCH  | one cycle: switch_program pulse, release hold
// ST_ERR     | one cycle: flag load_err, keep core held
module program_load_ctrl
    import program_load_pkg::*;
#(
    parameter int         IMEM_AW     = 12,
    parameter int         TIMEOUT_CYC = 65535,
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    output logic               imem_wen,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        imem_wdata,
    output logic               cpu_hold,
    output logic               switch_program,
    output logic [31:0]        SPART_pc,
    output logic               busy,
    output logic               load_err,
    output logic [15:0]        words_loaded
);

    localparam int               TMR_W      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);
    localparam logic [IMEM_AW:0] IDX_ONE    = (IMEM_AW + 1)'(1);
    localparam logic [32:0]      IMEM_WORDS = 33'd1 << IMEM_AW;

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [IMEM_AW:0]   word_idx_q, word_idx_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               imem_wen_q, imem_wen_d;
    logic [IMEM_AW-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]        imem_wdata_q, imem_wdata_d;
    logic               hold_q, hold_d;
    logic               switch_q, switch_d;
    logic [31:0]        spart_pc_q, spart_pc_d;
    logic               err_q, err_d;
    logic [15:0]        words_q, words_d;

    logic        sync_hit;
    logic        tmr_run;
    logic        timeout;
    logic        pack_en;
    logic        pack_clear;
    logic [31:0] pack_word;
    logic        word_done;
    logic        range_err;
    logic        last_word;

    assign sync_hit = (state_q == ST_IDLE) && rx_valid && (rx_data == SYNC_BYTE);
    assign tmr_run  = (state_q == ST_HDR_PC) || (state_q == ST_HDR_CNT) || (state_q == ST_DATA);
    assign timeout  = tmr_run && !rx_valid && (tmr_q == '0);
    // CHECK still feeds the packer: at full rate the first data byte lands there.
    assign pack_en    = rx_valid && (tmr_run || (state_q == ST_CHECK));
    assign pack_clear = sync_hit || timeout;

    assign range_err = ((pc_q >> IMEM_AW) != 32'd0) ||
                       (({1'b0, pc_q} + {1'b0, cnt_q}) > IMEM_WORDS);
    // cnt_q fits in IMEM_AW+1 bits whenever DATA is entered.
    assign last_word = ((word_idx_q + IDX_ONE) == cnt_q[IMEM_AW:0]);

    byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (pack_clear),
        .byte_valid_i (pack_en),
        .byte_i       (rx_data),
        .word_o       (pack_word),
        .word_done_o  (word_done)
    );

    always_comb begin
        tmr_d = tmr_q - TMR_ONE;
        if (!tmr_run || rx_valid || (tmr_q == '0)) begin
            tmr_d = TMR_RELOAD;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        cnt_d        = cnt_q;
        word_idx_d   = word_idx_q;
        imem_wen_d   = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        hold_d       = hold_q;
        spart_pc_d   = spart_pc_q;
        err_d        = err_q;
        words_d      = words_q;

        unique case (state_q)
            ST_IDLE: begin
                if (sync_hit) begin
                    state_d    = ST_HDR_PC;
                    hold_d     = 1'b1;
                    err_d      = 1'b0;
                    words_d    = '0;
                    word_idx_d = '0;
                end
            end
            ST_HDR_PC: begin
                if (timeout) begin
                    state_d = ST_ERR;
                end else if (word_done) begin
                    pc_d    = pack_word;
                    state_d = ST_HDR_CNT;
                end
            end
            ST_HDR_CNT: begin
                if (timeout) begin
                    state_d = ST_ERR;
                end else if (word_done) begin
                    cnt_d   = pack_word;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                // An empty frame just restarts the core; its PC is not range-checked.
                if (cnt_q == 32'd0) begin
                    spart_pc_d = pc_q;
                    state_d    = ST_SWITCH;
                end else if (range_err) begin
                    state_d = ST_ERR;
                end else begin
                    spart_pc_d = pc_q;
                    state_d    = ST_DATA;
                end
            end
            ST_DATA: begin
                if (timeout) begin
                    state_d = ST_ERR;
                end else if (word_done) begin
                    imem_wen_d   = 1'b1;
                    imem_addr_d  = pc_q[IMEM_AW-1:0] + word_idx_q[IMEM_AW-1:0];
                    imem_wdata_d = pack_word;
                    word_idx_d   = word_idx_q + IDX_ONE;
                    if (words_q != 16'hFFFF) begin
                        words_d = words_q + 16'd1;
                    end
                    if (last_word) begin
                        state_d = ST_SWITCH;
                    end
                end
            end
            ST_SWITCH: begin
                hold_d  = 1'b0;
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d == ST_ERR) begin
            err_d = 1'b1;
        end
        switch_d = (state_d == ST_SWITCH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pc_q         <= '0;
            cnt_q        <= '0;
            word_idx_q   <= '0;
            tmr_q        <= TMR_RELOAD;
            imem_wen_q   <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            hold_q       <= 1'b0;
            switch_q     <= 1'b0;
            spart_pc_q   <= '0;
            err_q        <= 1'b0;
            words_q      <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            cnt_q        <= cnt_d;
            word_idx_q   <= word_idx_d;
            tmr_q        <= tmr_d;
            imem_wen_q   <= imem_wen_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            hold_q       <= hold_d;
            switch_q     <= switch_d;
            spart_pc_q   <= spart_pc_d;
            err_q        <= err_d;
            words_q      <= words_d;
        end
    end

    assign imem_wen       = imem_wen_q;
    assign imem_addr      = imem_addr_q;
    assign imem_wdata     = imem_wdata_q;
    assign cpu_hold       = hold_q;
    assign switch_program = switch_q;
    assign SPART_pc       = spart_pc_q;
    assign busy           = (state_q != ST_IDLE);
    assign load_err       = err_q;
    assign words_loaded   = words_q;

endmodule

// File: tb/tb_program_load_ctrl.sv
// Directed bench for program_load_ctrl: frames driven byte by byte, IMEM and
// switch activity captured by a monitor and compared against hand values.
module tb_program_load_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        imem_wen;
    logic [11:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        switch_program;
    logic [31:0] SPART_pc;
    logic        busy;
    logic        load_err;
    logic [15:0] words_loaded;

    program_load_ctrl #(
        .IMEM_AW     (12),
        .TIMEOUT_CYC (100),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .imem_wen       (imem_wen),
        .imem_addr      (imem_addr),
        .imem_wdata     (imem_wdata),
        .cpu_hold       (cpu_hold),
        .switch_program (switch_program),
        .SPART_pc       (SPART_pc),
        .busy           (busy),
        .load_err       (load_err),
        .words_loaded   (words_loaded)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Monitor state
    logic [31:0] mem [0:4095];
    int          wr_cnt, sw_cnt, dbl_sw, dbl_wen, addr_gap;
    logic        hold_after, hold_during, prev_sw, prev_wen;
    logic [31:0] sw_pc;
    logic [11:0] last_addr;

    task automatic clear_mon();
        wr_cnt      = 0;
        sw_cnt      = 0;
        dbl_sw      = 0;
        dbl_wen     = 0;
        addr_gap    = 0;
        hold_after  = 1'b1;
        hold_during = 1'b0;
        sw_pc       = 32'hFFFF_FFFF;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
        prev_sw  = 1'b0;
        prev_wen = 1'b0;
        last_addr = 12'h0;
        clear_mon();
    end

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (imem_wen) begin
                if (wr_cnt != 0 && imem_addr != last_addr + 12'd1) addr_gap++;
                if (prev_wen) dbl_wen++;
                mem[imem_addr] = imem_wdata;
                last_addr = imem_addr;
                wr_cnt++;
            end
            if (prev_sw) hold_after = cpu_hold;
            if (switch_program) begin
                if (prev_sw) dbl_sw++;
                sw_cnt++;
                sw_pc = SPART_pc;
                hold_during = cpu_hold;
            end
            prev_sw  = switch_program;
            prev_wen = imem_wen;
        end else begin
            prev_sw  = 1'b0;
            prev_wen = 1'b0;
        end
    end

    // Called at a negedge; leaves rx_valid high so consecutive calls are back-to-back.
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8]);
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input string tag);
        rx_valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        chk(tag, {31'd0, busy}, 32'd0);
        idle(2);
    endtask

    function automatic logic [31:0] t5w(input int i);
        return 32'h5A00_0000 + 32'(i) * 32'h0001_0203;
    endfunction

    int err_at, idle_at, bad;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_wen",   {31'd0, imem_wen}, 32'd0);
        chk("rst_hold",  {31'd0, cpu_hold}, 32'd0);
        chk("rst_sw",    {31'd0, switch_program}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_err",   {31'd0, load_err}, 32'd0);
        chk("rst_pc",    SPART_pc, 32'd0);
        chk("rst_words", {16'd0, words_loaded}, 32'd0);

        // Test 1: basic two-word frame
        clear_mon();
        send_byte(8'hA5);
        chk("t1_hold_rise", {31'd0, cpu_hold}, 32'd1);
        chk("t1_busy",      {31'd0, busy}, 32'd1);
        send_word(32'h0000_0010);
        send_word(32'h0000_0002);
        send_word(32'hDEAD_BEEF);
        send_word(32'h1234_5678);
        wait_done("t1_done");
        chk("t1_mem10",      mem[12'h010], 32'hDEAD_BEEF);
        chk("t1_mem11",      mem[12'h011], 32'h1234_5678);
        chk("t1_wr_cnt",     32'(wr_cnt), 32'd2);
        chk("t1_sw_cnt",     32'(sw_cnt), 32'd1);
        chk("t1_sw_single",  32'(dbl_sw), 32'd0);
        chk("t1_sw_pc",      sw_pc, 32'h10);
        chk("t1_hold_in_sw", {31'd0, hold_during}, 32'd1);
        chk("t1_hold_fall",  {31'd0, hold_after}, 32'd0);
        chk("t1_words",      {16'd0, words_loaded}, 32'd2);
        chk("t1_err",        {31'd0, load_err}, 32'd0);

        // Test 3: range error leaves SPART_pc and keeps core held
        clear_mon();
        send_byte(8'hA5);
        send_word(32'h0000_0FFF);
        send_word(32'h0000_0002);
        wait_done("t3_done");
        chk("t3_err",    {31'd0, load_err}, 32'd1);
        chk("t3_wr_cnt", 32'(wr_cnt), 32'd0);
        chk("t3_sw_cnt", 32'(sw_cnt), 32'd0);
        chk("t3_pc",     SPART_pc, 32'h10);
        chk("t3_hold",   {31'd0, cpu_hold}, 32'd1);

        // Test 2: junk before SYNC, empty frame
        clear_mon();
        send_byte(8'h3C);
        send_byte(8'h00);
        idle(2);
        chk("t2_junk_busy", {31'd0, busy}, 32'd0);
        chk("t2_err_kept",  {31'd0, load_err}, 32'd1);
        send_byte(8'hA5);
        chk("t2_err_clr",   {31'd0, load_err}, 32'd0);
        send_word(32'h0);
        send_word(32'h0);
        wait_done("t2_done");
        chk("t2_wr_cnt", 32'(wr_cnt), 32'd0);
        chk("t2_sw_cnt", 32'(sw_cnt), 32'd1);
        chk("t2_sw_pc",  sw_pc, 32'h0);
        chk("t2_hold",   {31'd0, cpu_hold}, 32'd0);

        // Boundary: frame ending exactly at top of IMEM is legal
        clear_mon();
        send_byte(8'hA5);
        send_word(32'h0000_0FFE);
        send_word(32'h0000_0002);
        send_word(32'h1111_2222);
        send_word(32'h3333_4444);
        wait_done("tb_done");
        chk("tb_err",   {31'd0, load_err}, 32'd0);
        chk("tb_memFFE", mem[12'hFFE], 32'h1111_2222);
        chk("tb_memFFF", mem[12'hFFF], 32'h3333_4444);
        chk("tb_sw_pc", sw_pc, 32'hFFE);

        // PC above IMEM range
        clear_mon();
        send_byte(8'hA5);
        send_word(32'h0000_1000);
        send_word(32'h0000_0001);
        wait_done("tr_done");
        chk("tr_err",    {31'd0, load_err}, 32'd1);
        chk("tr_wr_cnt", 32'(wr_cnt), 32'd0);

        // Test 4: timeout mid-word
        clear_mon();
        send_byte(8'hA5);
        send_word(32'h0000_0004);
        send_word(32'h0000_0003);
        send_word(32'hDEAD_BEEF);
        send_byte(8'h55);
        rx_valid = 1'b0;
        err_at  = -1;
        idle_at = -1;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (err_at < 0 && load_err) err_at = i;
            if (!busy) begin
                idle_at = i;
                break;
            end
        end
        chk("t4_err_cycle",  32'(err_at), 32'd100);
        chk("t4_idle_cycle", 32'(idle_at), 32'd101);
        chk("t4_wr_cnt",     32'(wr_cnt), 32'd1);
        chk("t4_addr",       {20'd0, last_addr}, 32'd4);
        chk("t4_mem4",       mem[12'h004], 32'hDEAD_BEEF);
        chk("t4_words",      {16'd0, words_loaded}, 32'd1);
        idle(2);
        clear_mon();
        send_byte(8'hA5);
        send_word(32'h0000_0020);
        send_word(32'h0000_0001);
        send_word(32'hCAFE_F00D);
        wait_done("t4b_done");
        chk("t4b_err",   {31'd0, load_err}, 32'd0);
        chk("t4b_mem20", mem[12'h020], 32'hCAFE_F00D);
        chk("t4b_hold",  {31'd0, cpu_hold}, 32'd0);

        // Test 5: 64 words at one byte per cycle
        clear_mon();
        send_byte(8'hA5);
        send_word(32'h0000_0100);
        send_word(32'h0000_0040);
        for (int i = 0; i < 64; i++) send_word(t5w(i));
        wait_done("t5_done");
        bad = 0;
        for (int i = 0; i < 64; i++) if (mem[256 + i] !== t5w(i)) bad++;
        chk("t5_wr_cnt",  32'(wr_cnt), 32'd64);
        chk("t5_data",    32'(bad), 32'd0);
        chk("t5_addr_gap", 32'(addr_gap), 32'd0);
        chk("t5_wen_1cyc", 32'(dbl_wen), 32'd0);
        chk("t5_last",    {20'd0, last_addr}, 32'h13F);
        chk("t5_words",   {16'd0, words_loaded}, 32'd64);
        chk("t5_sw_pc",   sw_pc, 32'h100);

        // Test 6: reset in DATA after 3 words
        clear_mon();
        send_byte(8'hA5);
        send_word(32'h0000_0040);
        send_word(32'h0000_0008);
        send_word(32'hA1A1_A1A1);
        send_word(32'hB2B2_B2B2);
        send_word(32'hC3C3_C3C3);
        send_byte(8'hD4);
        send_byte(8'hD4);
        rx_valid = 1'b0;
        chk("t6_wr_cnt", 32'(wr_cnt), 32'd3);
        chk("t6_pre_pc", SPART_pc, 32'h40);
        rst = 1'b1;
        #1;
        chk("t6_rst_ctl", {27'd0, imem_wen, cpu_hold, switch_program, busy, load_err}, 32'd0);
        chk("t6_rst_pc",    SPART_pc, 32'd0);
        chk("t6_rst_addr",  {20'd0, imem_addr}, 32'd0);
        chk("t6_rst_wdata", imem_wdata, 32'd0);
        chk("t6_rst_words", {16'd0, words_loaded}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_mon();
        send_byte(8'hA5);
        send_word(32'h0000_0050);
        send_word(32'h0000_0001);
        send_word(32'h0BAD_C0DE);
        wait_done("t6b_done");
        chk("t6b_mem50", mem[12'h050], 32'h0BAD_C0DE);
        chk("t6b_sw_cnt", 32'(sw_cnt), 32'd1);
        chk("t6b_words",  {16'd0, words_loaded}, 32'd1);
        chk("t6b_mem43",  mem[12'h043], 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
